// File: rtl/fast_accel_hls_deadlock_detect_unit.sv
// Per-process deadlock detection node: merges incoming dependence sets, filters candidate
// cycles through this process for persistence, and holds a sticky report until acknowledged.
module fast_accel_hls_deadlock_detect_unit_v2 #(
  parameter int PROC_NUM      = 4,
  parameter int PROC_ID       = 0,
  parameter int IN_CHAN_NUM   = 2,
  parameter int OUT_CHAN_NUM  = 3,
  parameter int STABLE_THRESH = 8,
  parameter int CNT_W         = $clog2(STABLE_THRESH + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_report_valid,
  output logic [PROC_NUM-1:0]             dl_report_dep,
  output logic [OUT_CHAN_NUM-1:0]         dl_report_chan,
  input  logic                            dl_report_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_THRESH - 1);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  state_t              state;
  state_t              state_nxt;
  logic [PROC_NUM-1:0] dep_reg;
  logic [PROC_NUM-1:0] dep_prev;
  logic [PROC_NUM-1:0] dep_comb;
  logic [PROC_NUM-1:0] dep_sel;
  logic [CNT_W-1:0]    cnt;
  logic                gate_open;
  logic                blocked;
  logic                cand;
  logic                same_dep;
  logic                hit_last;
  logic                capture;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) dep_comb |= in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // Once a deadlock is flagged globally, only a passing token lets new dependence info in.
  assign gate_open = ~dl_detect_in | (|token_in_vec);
  assign dep_sel   = gate_open ? dep_comb : dep_reg;
  assign blocked   = |proc_dep_vld_vec;
  assign cand      = gate_open & blocked & dep_sel[PROC_ID];
  assign same_dep  = (dep_sel == dep_prev);
  assign hit_last  = (cnt == CNT_LAST);

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF_BIT;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dep_reg       <= '0;
      token_out_vec <= '0;
    end else begin
      dep_reg       <= blocked ? dep_sel : '0;
      token_out_vec <= (origin | ((|token_in_vec) & ~token_clear)) ? proc_dep_vld_vec : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cand) state_nxt = (STABLE_THRESH == 1) ? DETECT : ARMED;
      ARMED: begin
        if (!cand)                     state_nxt = IDLE;
        else if (same_dep && hit_last) state_nxt = DETECT;
      end
      DETECT:  if (dl_report_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dl_detect_out   = (state == DETECT);
    dl_report_valid = (state == DETECT);
  end

  // Persistence counter and reference set; a changed set restarts the window at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dep_prev <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cand) begin
            cnt      <= (STABLE_THRESH == 1) ? '0 : CNT_W'(1);
            dep_prev <= dep_sel;
          end
        end
        ARMED: begin
          if (!cand) begin
            cnt <= '0;
          end else if (!same_dep) begin
            cnt      <= CNT_W'(1);
            dep_prev <= dep_sel;
          end else if (!hit_last) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DETECT:  if (dl_report_ack) cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Report fields load only on entry to DETECT and otherwise hold, including after ack.
  assign capture = (state != DETECT) && (state_nxt == DETECT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dl_report_dep  <= '0;
      dl_report_chan <= '0;
    end else if (capture) begin
      dl_report_dep  <= dep_sel;
      dl_report_chan <= proc_dep_vld_vec;
    end
  end

endmodule

// File: tb/tb_fast_accel_hls_deadlock_detect_unit_v2.sv
// Directed bench for the deadlock detection node: run-length model checked every cycle,
// plus hand-computed timing and report values.
module tb_fast_accel_hls_deadlock_detect_unit_v2;

  localparam int P  = 4;
  localparam int ID = 0;
  localparam int I  = 2;
  localparam int O  = 3;
  localparam int TH = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [O-1:0]   proc_dep_vld_vec;
  logic [I-1:0]   in_chan_dep_vld_vec;
  logic [I*P-1:0] in_chan_dep_data_vec;
  logic [I-1:0]   token_in_vec;
  logic           dl_detect_in;
  logic           origin;
  logic           token_clear;
  logic           dl_report_ack;
  logic [O-1:0]   out_chan_dep_vld_vec;
  logic [P-1:0]   out_chan_dep_data;
  logic [O-1:0]   token_out_vec;
  logic           dl_detect_out;
  logic           dl_report_valid;
  logic [P-1:0]   dl_report_dep;
  logic [O-1:0]   dl_report_chan;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  fast_accel_hls_deadlock_detect_unit_v2 #(
    .PROC_NUM(P), .PROC_ID(ID), .IN_CHAN_NUM(I), .OUT_CHAN_NUM(O), .STABLE_THRESH(TH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .proc_dep_vld_vec(proc_dep_vld_vec),
    .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
    .in_chan_dep_data_vec(in_chan_dep_data_vec),
    .token_in_vec(token_in_vec),
    .dl_detect_in(dl_detect_in),
    .origin(origin),
    .token_clear(token_clear),
    .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
    .out_chan_dep_data(out_chan_dep_data),
    .token_out_vec(token_out_vec),
    .dl_detect_out(dl_detect_out),
    .dl_report_valid(dl_report_valid),
    .dl_report_dep(dl_report_dep),
    .dl_report_chan(dl_report_chan),
    .dl_report_ack(dl_report_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a deadlock is declared once the same candidate set has been seen TH cycles in a row.
  logic [P-1:0] m_dep_reg, m_last, m_rep_dep;
  logic [O-1:0] m_rep_chan, m_tok;
  bit           m_det;
  int           m_run;

  always @(posedge clock or negedge reset) begin : model_step
    logic [P-1:0] merged;
    logic [P-1:0] sel;
    bit           opn;
    bit           cnd;
    if (!reset) begin
      m_dep_reg  = '0;
      m_last     = '0;
      m_rep_dep  = '0;
      m_rep_chan = '0;
      m_tok      = '0;
      m_det      = 1'b0;
      m_run      = 0;
    end else begin
      merged = '0;
      for (int i = 0; i < I; i++)
        if (in_chan_dep_vld_vec[i]) merged = merged | in_chan_dep_data_vec[i*P +: P];
      opn = !dl_detect_in || (token_in_vec != 0);
      sel = opn ? merged : m_dep_reg;
      cnd = opn && (proc_dep_vld_vec != 0) && sel[ID];
      if (m_det) begin
        if (dl_report_ack) begin
          m_det = 1'b0;
          m_run = 0;
        end
      end else if (cnd) begin
        m_run  = (m_run > 0 && sel == m_last) ? m_run + 1 : 1;
        m_last = sel;
        if (m_run >= TH) begin
          m_det      = 1'b1;
          m_rep_dep  = sel;
          m_rep_chan = proc_dep_vld_vec;
          m_run      = 0;
        end
      end else begin
        m_run = 0;
      end
      m_dep_reg = (proc_dep_vld_vec != 0) ? sel : '0;
      m_tok     = (origin || (token_in_vec != 0 && !token_clear)) ? proc_dep_vld_vec : '0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_dep_vld",  out_chan_dep_vld_vec, proc_dep_vld_vec);
      check("cmp_dep_data", out_chan_dep_data, m_dep_reg | (P'(1) << ID));
      check("cmp_token",    token_out_vec, m_tok);
      check("cmp_detect",   dl_detect_out, m_det);
      check("cmp_valid",    dl_report_valid, m_det);
      check("cmp_rep_dep",  dl_report_dep, m_rep_dep);
      check("cmp_rep_chan", dl_report_chan, m_rep_chan);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    proc_dep_vld_vec     = '0;
    in_chan_dep_vld_vec  = '0;
    in_chan_dep_data_vec = '0;
    token_in_vec         = '0;
    dl_detect_in         = 1'b0;
    origin               = 1'b0;
    token_clear          = 1'b0;
    dl_report_ack        = 1'b0;
  endtask

  task automatic apply_cycle(input logic [P-1:0] ch0);
    proc_dep_vld_vec     = 3'b001;
    in_chan_dep_vld_vec  = 2'b01;
    in_chan_dep_data_vec = {4'b0000, ch0};
  endtask

  task automatic ack_and_clear();
    idle_inputs();
    dl_report_ack = 1'b1;
    tick();
    dl_report_ack = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;
    check("reset_detect", dl_detect_out, 1'b0);
    check("reset_rep_dep", dl_report_dep, 4'b0000);
    tick(2);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Idle for 20 cycles: only this process's own bit is visible.
    tick(20);
    check("idle_dep_data", out_chan_dep_data, 4'b0001);
    check("idle_detect", dl_detect_out, 1'b0);
    check("idle_token", token_out_vec, 3'b000);

    // Stable cycle: detection in cycle 8, ack in ARMED ignored.
    apply_cycle(4'b0011);
    tick(3);
    dl_report_ack = 1'b1;
    tick();
    dl_report_ack = 1'b0;
    tick(3);
    check("stable_c7_detect", dl_detect_out, 1'b0);
    tick();
    check("stable_c8_detect", dl_detect_out, 1'b1);
    check("stable_c8_valid", dl_report_valid, 1'b1);
    check("stable_rep_dep", dl_report_dep, 4'b0011);
    check("stable_rep_chan", dl_report_chan, 3'b001);
    dl_report_ack = 1'b1;
    tick();
    dl_report_ack = 1'b0;
    check("ack_detect", dl_detect_out, 1'b0);
    check("ack_valid", dl_report_valid, 1'b0);
    check("ack_rep_hold", dl_report_dep, 4'b0011);
    tick(7);
    check("redetect_early", dl_detect_out, 1'b0);
    tick();
    check("redetect", dl_detect_out, 1'b1);
    ack_and_clear();

    // Set changes at cycle 5: window restarts, detection in cycle 13.
    apply_cycle(4'b0011);
    tick(5);
    apply_cycle(4'b0111);
    tick(7);
    check("toggle_c12_detect", dl_detect_out, 1'b0);
    tick();
    check("toggle_c13_detect", dl_detect_out, 1'b1);
    check("toggle_rep_dep", dl_report_dep, 4'b0111);
    ack_and_clear();

    // One-cycle gap after 5 candidate cycles: 8 more cycles needed.
    apply_cycle(4'b0011);
    tick(5);
    proc_dep_vld_vec = 3'b000;
    tick();
    proc_dep_vld_vec = 3'b001;
    tick(7);
    check("gap_early", dl_detect_out, 1'b0);
    tick();
    check("gap_detect", dl_detect_out, 1'b1);
    ack_and_clear();

    // Global flag without token freezes dep_reg and drops ARMED back to IDLE.
    apply_cycle(4'b0011);
    tick(3);
    dl_detect_in         = 1'b1;
    in_chan_dep_data_vec = {4'b0000, 4'b1100};
    tick();
    check("frozen_dep", out_chan_dep_data, 4'b0011);
    tick(10);
    check("frozen_no_detect", dl_detect_out, 1'b0);
    check("frozen_dep_hold", out_chan_dep_data, 4'b0011);
    proc_dep_vld_vec = 3'b101;
    token_in_vec     = 2'b10;
    tick();
    check("token_fwd", token_out_vec, 3'b101);
    check("token_open_dep", out_chan_dep_data, 4'b1101);
    token_clear = 1'b1;
    tick();
    check("token_clear", token_out_vec, 3'b000);
    token_in_vec = 2'b00;
    origin       = 1'b1;
    tick();
    check("origin_wins", token_out_vec, 3'b101);
    idle_inputs();
    tick(3);

    // Asynchronous reset while in DETECT, then a full window again.
    apply_cycle(4'b0011);
    tick(8);
    check("pre_reset_detect", dl_detect_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_detect", dl_detect_out, 1'b0);
    check("async_valid", dl_report_valid, 1'b0);
    check("async_rep_dep", dl_report_dep, 4'b0000);
    check("async_rep_chan", dl_report_chan, 3'b000);
    check("async_dep_data", out_chan_dep_data, 4'b0001);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(7);
    check("post_reset_early", dl_detect_out, 1'b0);
    tick();
    check("post_reset_detect", dl_detect_out, 1'b1);
    ack_and_clear();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
